// File: rtl/uart_tx_8n1_if.sv
// uart_tx_8n1_if: byte handshake and status bundle between a producer (master) and the transmitter (slave)
interface uart_tx_8n1_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_ready;
    logic                  o_busy;
    logic                  o_done;
    modport master (output i_valid, i_data, input o_ready, o_busy, o_done);
    modport slave  (input i_valid, i_data, output o_ready, o_busy, o_done);
endinterface

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 serial transmitter; ports clk, async_reset_n, sync_reset, bus (valid/data/ready/busy/done), o_tx line
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_WIDTH   = 8
) (
    input  logic        clk,
    input  logic        async_reset_n,
    input  logic        sync_reset,
    uart_tx_8n1_if.slave bus,
    output logic        o_tx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(DATA_WIDTH - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic                  bit_end;
    assign bit_end     = cnt_q == CNT_MAX;
    assign o_tx        = tx_q;
    assign bus.o_ready = ready_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: if (bus.i_valid) begin
                state_d = START;
                shift_d = bus.i_data;
            end
            START: if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                if (bit_q == BIT_MAX) state_d = STOP;
                else bit_d = bit_q + 1'b1;
            end
            STOP: if (bit_end) state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
            bit_d = '0;
        end
        if (sync_reset) begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = '0;
        end
        // Outputs are computed from the next state so the registered line changes on the transition edge
        tx_d    = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
        ready_d = state_d == IDLE;
        busy_d  = !ready_d;
        done_d  = state_q == STOP && state_d == IDLE && !sync_reset;
    end
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb_uart_tx_8n1: directed self-checking bench for uart_tx_8n1 at N=10 and N=2
module tb_uart_tx_8n1;
    logic clk = 1'b0;
    logic run = 1'b0;
    logic rst_n = 1'b1;
    logic srst = 1'b0;
    logic tx, tx2;
    int checks = 0;
    int errors = 0;
    uart_tx_8n1_if #(.DATA_WIDTH(8)) bus ();
    uart_tx_8n1_if #(.DATA_WIDTH(8)) bus2 ();
    uart_tx_8n1 #(.CLKS_PER_BIT(10), .DATA_WIDTH(8)) dut (
        .clk(clk), .async_reset_n(rst_n), .sync_reset(srst), .bus(bus), .o_tx(tx));
    uart_tx_8n1 #(.CLKS_PER_BIT(2), .DATA_WIDTH(8)) dut2 (
        .clk(clk), .async_reset_n(rst_n), .sync_reset(srst), .bus(bus2), .o_tx(tx2));
    always #5 if (run) clk = ~clk;

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
        run = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data = 8'hFF;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks += 2;
        if (tx !== 1'b0) begin errors++; $display("FAIL pre_abort_tx: got %b want 0", tx); end
        if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL pre_abort_busy: got %b want 1", bus.o_busy); end
        run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (tx !== 1'b1) begin errors++; $display("FAIL async_tx: got %b want 1", tx); end
        if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL async_ready: got %b want 1", bus.o_ready); end
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", bus.o_busy); end
        if (bus.o_done !== 1'b0) begin errors++; $display("FAIL async_done: got %b want 0", bus.o_done); end
        #2 run = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        logic [9:0] fr;
        fr = 10'b1_1010_0101_0;
        bus.i_valid = 1'b1;
        bus.i_data = 8'hA5;
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_data = 8'h00;
        for (int t = 0; t < 100; t++) begin
            checks++;
            if (tx !== fr[t / 10]) begin errors++; $display("FAIL single_tx t=%0d: got %b want %b", t, tx, fr[t / 10]); end
            @(negedge clk);
        end
        checks += 2;
        if (bus.o_done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", bus.o_done); end
        if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.o_ready); end
        @(negedge clk);
        checks++;
        if (bus.o_done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", bus.o_done); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] f1, f2;
        logic ex;
        int pulses;
        f1 = 10'b1_0000_0000_0;
        f2 = 10'b1_1111_1111_0;
        pulses = 0;
        bus.i_valid = 1'b1;
        bus.i_data = 8'h00;
        @(negedge clk);
        bus.i_data = 8'hFF;
        for (int t = 0; t < 203; t++) begin
            ex = (t < 100) ? f1[t / 10] : (t == 100 || t > 200) ? 1'b1 : f2[(t - 101) / 10];
            checks += 2;
            if (tx !== ex) begin errors++; $display("FAIL b2b_tx t=%0d: got %b want %b", t, tx, ex); end
            if (bus.o_done !== (t == 100 || t == 201)) begin
                errors++;
                $display("FAIL b2b_done t=%0d: got %b want %b", t, bus.o_done, (t == 100 || t == 201));
            end
            if (bus.o_done === 1'b1) pulses++;
            if (t == 101) bus.i_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_ignored;
        logic [9:0] fr;
        fr = 10'b1_0101_1010_0;
        bus.i_valid = 1'b1;
        bus.i_data = 8'h5A;
        @(negedge clk);
        bus.i_valid = 1'b0;
        for (int t = 0; t < 100; t++) begin
            checks += 2;
            if (tx !== fr[t / 10]) begin errors++; $display("FAIL ign_tx t=%0d: got %b want %b", t, tx, fr[t / 10]); end
            if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL ign_ready t=%0d: got %b want 0", t, bus.o_ready); end
            if (t == 30) begin bus.i_valid = 1'b1; bus.i_data = 8'h3C; end
            if (t == 36) bus.i_valid = 1'b0;
            if (t == 50) bus.i_data = 8'hFF;
            @(negedge clk);
        end
        checks += 2;
        if (bus.o_done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b want 1", bus.o_done); end
        if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL ign_ready_end: got %b want 1", bus.o_ready); end
        @(negedge clk);
        checks += 2;
        if (tx !== 1'b1) begin errors++; $display("FAIL ign_idle_tx: got %b want 1", tx); end
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL ign_idle_busy: got %b want 0", bus.o_busy); end
    endtask

    task automatic test_abort;
        logic [9:0] fr;
        fr = 10'b1_1000_0001_0;
        bus.i_valid = 1'b1;
        bus.i_data = 8'h00;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (44) @(negedge clk);
        srst = 1'b1;
        bus.i_valid = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        bus.i_valid = 1'b0;
        checks += 4;
        if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b want 1", tx); end
        if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", bus.o_ready); end
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.o_busy); end
        if (bus.o_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", bus.o_done); end
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            checks++;
            if (bus.o_done !== 1'b0 || tx !== 1'b1) begin
                errors++;
                $display("FAIL abort_quiet t=%0d: got done=%b tx=%b want done=0 tx=1", t, bus.o_done, tx);
            end
        end
        bus.i_valid = 1'b1;
        bus.i_data = 8'h81;
        @(negedge clk);
        bus.i_valid = 1'b0;
        for (int t = 0; t < 100; t++) begin
            checks++;
            if (tx !== fr[t / 10]) begin errors++; $display("FAIL abort_next_tx t=%0d: got %b want %b", t, tx, fr[t / 10]); end
            @(negedge clk);
        end
        checks++;
        if (bus.o_done !== 1'b1) begin errors++; $display("FAIL abort_next_done: got %b want 1", bus.o_done); end
        @(negedge clk);
    endtask

    task automatic test_min_divider;
        logic [9:0] fr;
        fr = 10'b1_1100_0011_0;
        bus2.i_valid = 1'b1;
        bus2.i_data = 8'hC3;
        @(negedge clk);
        bus2.i_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            checks += 2;
            if (tx2 !== fr[t / 2]) begin errors++; $display("FAIL n2_tx t=%0d: got %b want %b", t, tx2, fr[t / 2]); end
            if (bus2.o_busy !== 1'b1) begin errors++; $display("FAIL n2_busy t=%0d: got %b want 1", t, bus2.o_busy); end
            @(negedge clk);
        end
        checks += 2;
        if (bus2.o_done !== 1'b1) begin errors++; $display("FAIL n2_done: got %b want 1", bus2.o_done); end
        if (bus2.o_ready !== 1'b1) begin errors++; $display("FAIL n2_ready: got %b want 1", bus2.o_ready); end
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data = 8'h00;
        bus2.i_valid = 1'b0;
        bus2.i_data = 8'h00;
        test_reset;
        test_single;
        test_back_to_back;
        test_ignored;
        test_abort;
        test_min_divider;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_8n1.md
# uart_tx_8n1

Serial transmitter that turns a byte handed over on a valid/ready handshake into an asynchronous 8N1 line frame on a single output bit. The frame is one start bit, DATA_WIDTH data bits sent LSB first, and one stop bit. It sits behind any byte producer in the design and drives the board-level TX pin, or a paired receiver in simulation. Bit timing comes from a cycle counter clocked by the 100 MHz system clock; no external tick is needed.

## Interface

Parameters:
- CLKS_PER_BIT, default 10: clock cycles per line bit. Legal values are ≥ 2; 10 gives 10 Mbaud at 100 MHz.
- DATA_WIDTH, default 8: number of data bits per frame.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- async_reset_n  input  1  asynchronous, active-low reset.
- sync_reset  input  1  synchronous, active-high clear. It aborts any frame in progress.
- i_valid  input  1  a byte is offered on i_data.
- i_data  input  DATA_WIDTH  byte to send. Sampled only on the accept edge.
- o_ready  output  1  transmitter can accept a byte. High only in IDLE.
- o_tx  output  1  serial line. Idles high.
- o_busy  output  1  a frame is in progress (state ≠ IDLE).
- o_done  output  1  one-cycle pulse when a frame has completed.

## Operation

- States are IDLE, START, DATA and STOP.
  - IDLE: o_tx=1, o_ready=1. If i_valid=1, the byte is accepted on that edge, i_data is latched into the shift register, and the state moves to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: o_tx=shift[0] for CLKS_PER_BIT cycles per bit. The register shifts right after each bit. After DATA_WIDTH bits the state moves to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Counters:
  - Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Bit index width is $clog2(DATA_WIDTH+1).
  - Both counters clear on every state change.
- Latching: i_data changes after the accept edge have no effect on the frame in flight.
- i_valid outside IDLE is ignored. There is no queueing; the producer must hold i_valid until it sees o_ready.
- o_done is high for exactly one cycle: the first IDLE cycle after STOP.
- o_busy is the registered complement of o_ready.
- All outputs are registered. There is no combinational path from any input to o_tx.

## Timing

- Reset, async_reset_n=0, takes effect immediately regardless of clk:
  - state=IDLE
  - o_tx=1
  - o_ready=1
  - o_busy=0
  - o_done=0
  - counters=0
  - shift register=0
- sync_reset=1 at an edge forces the same values at that edge. It wins over i_valid in the same cycle, so no byte is accepted.
- Reset mid-frame: the line returns high immediately. No o_done pulse is produced for the aborted frame.
- Latency: let edge E be the accept edge. o_tx falls after E and stays low for cycles E+1..E+N, where N=CLKS_PER_BIT.
  - Data bit k occupies cycles E+1+(k+1)N .. E+(k+2)N.
  - The stop bit occupies the last N cycles of the frame.
- Frame length is (DATA_WIDTH+2)·N cycles. o_done and o_ready rise on cycle E+(DATA_WIDTH+2)N+1.
- Back-to-back: if i_valid is held high, the next byte is accepted on the o_done cycle. The line idles high for exactly 1 cycle between the stop bit and the next start bit. Sustained throughput is one frame per (DATA_WIDTH+2)·N+1 cycles.
- Simultaneous events:
  - i_valid rising in the same cycle as o_done: accepted.
  - i_valid and sync_reset together: reset wins.
- No gated or enabled clock. If clk stops, state freezes; async reset still works.

## Test plan

- Reset values: assert async_reset_n=0 mid-cycle with clk stopped. Required: o_tx=1, o_ready=1, o_busy=0 and o_done=0 immediately, not at the next edge.
- Single frame, N=10: send 0xA5. Required on o_tx, 10 cycles per symbol: 0 (start), 1,0,1,0,0,1,0,1, 1 (stop). Then o_done is high for 1 cycle at accept+101, together with o_ready=1.
- Back-to-back: hold i_valid=1 and send 0x00 then 0xFF. Required: exactly 1 high idle cycle between the first stop bit and the second start bit. Second frame bits are 0, eight 1s, 1. Two o_done pulses, 101 cycles apart.
- Ignored input: pulse i_valid with 0x3C during the DATA state of frame 0x5A, and change i_data mid-frame. Required: only 0x5A is transmitted, and o_ready stays 0 until the frame ends.
- Mid-frame abort:
  - Step 1: assert sync_reset for 1 cycle during data bit 3. Required: o_tx=1 and o_ready=1 at that edge, with no o_done.
  - Step 2: a new frame 0x81 starting after the abort is transmitted correctly.
- Minimum divider, N=2: send 0xC3. Required: every symbol lasts exactly 2 cycles, and the total frame is 20 cycles.
